// File: rtl/layer_train_sequencer_pkg.sv
// Shared types and widths for the layer training sequencer.
package layer_train_sequencer_pkg;

    // Fixed-point element types used by the neuron layer (unsigned, 0..1 range).
    typedef logic [7:0] zero2one_t;
    typedef logic [7:0] frac_t;

    localparam int SEQ_IDX_W   = 16;
    localparam int SEQ_EPOCH_W = 8;
    localparam int SEQ_PHASE_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        LEARN  = 3'd3,
        EMIT   = 3'd4,
        DONE   = 3'd5
    } seq_state_t;

endpackage

// File: rtl/layer_train_sequencer_if.sv
// Sample, result and layer-side bundle between the sequencer and its environment.
//
// Handshake rule for both streams (s_* and r_*): a transfer happens on the rising
// clock edge where valid and ready are both 1. The producer holds valid and its
// payload stable until that edge; ready may change freely and never depends
// combinationally on valid. layer_valid/layer_learn are plain strobes, no ready.
interface layer_train_sequencer_if
    import layer_train_sequencer_pkg::*;
#(
    parameter int N = 16,
    parameter int M = 48
);
    // sample stream (environment -> sequencer)
    logic                  s_valid;
    logic                  s_ready;
    zero2one_t [N-1:0]     s_in;
    zero2one_t [M-1:0]     s_expected;

    // layer drive and response
    logic                  layer_valid;
    logic                  layer_learn;
    zero2one_t [N-1:0]     layer_in;
    zero2one_t [M-1:0]     layer_expected_out;
    zero2one_t [M-1:0]     layer_out;

    // result stream (sequencer -> environment)
    logic                  r_valid;
    logic                  r_ready;
    zero2one_t [M-1:0]     r_out;

    modport master (
        input  s_valid, s_in, s_expected, layer_out, r_ready,
        output s_ready, layer_valid, layer_learn, layer_in, layer_expected_out,
               r_valid, r_out
    );

    modport slave (
        output s_valid, s_in, s_expected, layer_out, r_ready,
        input  s_ready, layer_valid, layer_learn, layer_in, layer_expected_out,
               r_valid, r_out
    );

endinterface

// File: rtl/layer_train_sequencer_seq_phase_counter.sv
// Loadable down-counter timing the SETTLE and LEARN phases.
// Load with (cycles - 1); o_terminal is high during the last cycle of the phase.
module layer_train_sequencer_seq_phase_counter
    import layer_train_sequencer_pkg::*;
#(
    parameter int W = SEQ_PHASE_W
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_terminal
);

    logic [W-1:0] r_count;

    // Load has priority; counting stops at zero so an idle counter never wraps.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_terminal = (r_count == '0);

endmodule

// File: rtl/layer_train_sequencer.sv
// Sequences one learning layer through infer/train passes over samples x epochs.
// All outputs are flops; strobes are decoded from the next state so they line
// up exactly with the state they belong to.
module layer_train_sequencer
    import layer_train_sequencer_pkg::*;
#(
    parameter int N             = 16,
    parameter int M             = 48,
    parameter int SETTLE_CYCLES = 2,
    parameter int LEARN_CYCLES  = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   mode_learn,
    input  logic [SEQ_IDX_W-1:0]   num_samples,
    input  logic [SEQ_EPOCH_W-1:0] num_epochs,
    layer_train_sequencer_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic [SEQ_IDX_W-1:0]   sample_idx,
    output logic [SEQ_EPOCH_W-1:0] epoch_idx,
    output seq_state_t             dbg_state
);

    localparam logic [SEQ_PHASE_W-1:0] SETTLE_PRELOAD = SEQ_PHASE_W'(SETTLE_CYCLES - 1);
    localparam logic [SEQ_PHASE_W-1:0] LEARN_PRELOAD  = SEQ_PHASE_W'(LEARN_CYCLES - 1);

    seq_state_t             r_state;
    logic                   r_mode_learn;
    logic [SEQ_IDX_W-1:0]   r_num_samples;
    logic [SEQ_EPOCH_W-1:0] r_num_epochs;
    logic [SEQ_IDX_W-1:0]   r_sample_idx;
    logic [SEQ_EPOCH_W-1:0] r_epoch_idx;
    zero2one_t [N-1:0]      r_layer_in;
    zero2one_t [M-1:0]      r_layer_exp;
    zero2one_t [M-1:0]      r_result;
    logic                   r_s_ready;
    logic                   r_layer_valid;
    logic                   r_layer_learn;
    logic                   r_res_valid;
    logic                   r_busy;
    logic                   r_done;

    seq_state_t             w_next;
    logic                   w_abort;
    logic                   w_accept;
    logic                   w_emit_fire;
    logic                   w_last_sample;
    logic                   w_last_epoch;
    logic                   w_capture;
    logic                   w_cnt_load;
    logic [SEQ_PHASE_W-1:0] w_cnt_load_val;
    logic                   w_cnt_en;
    logic                   w_cnt_term;

    layer_train_sequencer_seq_phase_counter #(
        .W (SEQ_PHASE_W)
    ) u_seq_phase_counter (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_en       (w_cnt_en),
        .o_terminal (w_cnt_term)
    );

    // Next-state, handshake qualification and phase-counter control.
    always_comb begin
        w_abort        = abort && (r_state != IDLE);
        w_accept       = (r_state == LOAD) && r_s_ready && bus.s_valid && !w_abort;
        w_emit_fire    = (r_state == EMIT) && r_res_valid && bus.r_ready && !w_abort;
        w_last_sample  = (r_sample_idx == r_num_samples - SEQ_IDX_W'(1));
        w_last_epoch   = (r_epoch_idx == r_num_epochs - SEQ_EPOCH_W'(1));
        w_capture      = (r_state == SETTLE) && w_cnt_term && !w_abort;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = SETTLE_PRELOAD;
        w_cnt_en       = (r_state == SETTLE) || (r_state == LEARN);
        w_next         = r_state;

        case (r_state)
            IDLE: begin
                if (start) begin
                    if ((num_samples == '0) || (num_epochs == '0)) w_next = DONE;
                    else                                           w_next = LOAD;
                end
            end
            LOAD: begin
                if (w_accept) begin
                    w_next         = SETTLE;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = SETTLE_PRELOAD;
                end
            end
            SETTLE: begin
                if (w_cnt_term) begin
                    if (r_mode_learn) begin
                        w_next         = LEARN;
                        w_cnt_load     = 1'b1;
                        w_cnt_load_val = LEARN_PRELOAD;
                    end else begin
                        w_next = EMIT;
                    end
                end
            end
            LEARN: begin
                if (w_cnt_term) w_next = EMIT;
            end
            EMIT: begin
                if (w_emit_fire) begin
                    if (w_last_sample && w_last_epoch) w_next = DONE;
                    else                               w_next = LOAD;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase

        // abort beats every handshake; start in IDLE is unaffected by it
        if (w_abort) w_next = IDLE;
    end

    // State, registered strobes, run configuration, indices and data holding regs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_mode_learn  <= 1'b0;
            r_num_samples <= '0;
            r_num_epochs  <= '0;
            r_sample_idx  <= '0;
            r_epoch_idx   <= '0;
            r_layer_in    <= '0;
            r_layer_exp   <= '0;
            r_result      <= '0;
            r_s_ready     <= 1'b0;
            r_layer_valid <= 1'b0;
            r_layer_learn <= 1'b0;
            r_res_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_s_ready     <= (w_next == LOAD);
            r_layer_valid <= (w_next == SETTLE) || (w_next == LEARN);
            r_layer_learn <= (w_next == LEARN);
            r_res_valid   <= (w_next == EMIT);
            r_busy        <= (w_next != IDLE);
            r_done        <= (w_next == DONE);

            if ((r_state == IDLE) && start) begin
                r_mode_learn  <= mode_learn;
                r_num_samples <= num_samples;
                r_num_epochs  <= num_epochs;
                r_sample_idx  <= '0;
                r_epoch_idx   <= '0;
            end

            if (w_accept) begin
                r_layer_in  <= bus.s_in;
                r_layer_exp <= bus.s_expected;
            end

            if (w_capture) begin
                r_result <= bus.layer_out;
            end

            if (w_emit_fire && !(w_last_sample && w_last_epoch)) begin
                if (w_last_sample) begin
                    r_sample_idx <= '0;
                    r_epoch_idx  <= r_epoch_idx + SEQ_EPOCH_W'(1);
                end else begin
                    r_sample_idx <= r_sample_idx + SEQ_IDX_W'(1);
                end
            end
        end
    end

    assign bus.s_ready            = r_s_ready;
    assign bus.layer_valid        = r_layer_valid;
    assign bus.layer_learn        = r_layer_learn;
    assign bus.layer_in           = r_layer_in;
    assign bus.layer_expected_out = r_layer_exp;
    assign bus.r_valid            = r_res_valid;
    assign bus.r_out              = r_result;
    assign busy                   = r_busy;
    assign done                   = r_done;
    assign sample_idx             = r_sample_idx;
    assign epoch_idx              = r_epoch_idx;
    assign dbg_state              = r_state;

endmodule

// File: tb/tb_layer_train_sequencer.sv
// Directed bench for layer_train_sequencer with a behavioural layer model.
module tb_layer_train_sequencer;
    import layer_train_sequencer_pkg::*;

    localparam int N      = 16;
    localparam int M      = 48;
    localparam int SETTLE = 2;
    localparam int LEARN  = 3;
    localparam int CW     = 8 * M;

    typedef zero2one_t [N-1:0] in_vec_t;
    typedef zero2one_t [M-1:0] out_vec_t;

    logic                   clock;
    logic                   reset_n;
    logic                   start;
    logic                   abort;
    logic                   mode_learn;
    logic [SEQ_IDX_W-1:0]   num_samples;
    logic [SEQ_EPOCH_W-1:0] num_epochs;
    logic                   busy;
    logic                   done;
    logic [SEQ_IDX_W-1:0]   sample_idx;
    logic [SEQ_EPOCH_W-1:0] epoch_idx;
    seq_state_t             dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    bit rdy_always;

    // cumulative monitor counters; tests compare differences
    int learn_cnt  = 0;
    int done_cnt   = 0;
    int busy_cnt   = 0;
    int srdy_cnt   = 0;
    int lvalid_cnt = 0;
    int excl_bad   = 0;

    layer_train_sequencer_if #(.N(N), .M(M)) bus ();

    layer_train_sequencer #(
        .N             (N),
        .M             (M),
        .SETTLE_CYCLES (SETTLE),
        .LEARN_CYCLES  (LEARN)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .mode_learn  (mode_learn),
        .num_samples (num_samples),
        .num_epochs  (num_epochs),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .sample_idx  (sample_idx),
        .epoch_idx   (epoch_idx),
        .dbg_state   (dbg_state)
    );

    // clock / global time limit
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "time limit");
    end

    // stimulus patterns and layer model
    function automatic in_vec_t mk_in(input int k);
        in_vec_t v;
        for (int i = 0; i < N; i++) v[i] = zero2one_t'(k * 17 + i * 5 + 1);
        return v;
    endfunction

    function automatic out_vec_t mk_exp(input int k);
        out_vec_t v;
        for (int j = 0; j < M; j++) v[j] = zero2one_t'(k * 3 + j * 7 + 2);
        return v;
    endfunction

    function automatic out_vec_t layer_fn(input in_vec_t x);
        out_vec_t o;
        for (int j = 0; j < M; j++) o[j] = x[j % N] ^ zero2one_t'(j * 3 + 5);
        return o;
    endfunction

    always_comb bus.layer_out = layer_fn(bus.layer_in);

    // monitor, sampled on the falling edge
    always @(negedge clock) begin
        if (bus.layer_learn) learn_cnt++;
        if (done)            done_cnt++;
        if (busy)            busy_cnt++;
        if (bus.s_ready)     srdy_cnt++;
        if (bus.layer_valid) lvalid_cnt++;
        if (bus.layer_valid && (bus.s_ready || bus.r_valid || done || !busy)) excl_bad++;
    end

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] want);
        n_checks++;
        if (obs !== want) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, want);
        end
    endtask

    // driver tasks: all start and end just after a rising edge
    task automatic start_run(input bit learn, input int ns, input int ne);
        mode_learn  = learn;
        num_samples = SEQ_IDX_W'(ns);
        num_epochs  = SEQ_EPOCH_W'(ne);
        start       = 1'b1;
        @(posedge clock); #1;
        start       = 1'b0;
    endtask

    task automatic send_sample(input int k);
        bit seen = 1'b0;
        bus.s_valid    = 1'b1;
        bus.s_in       = mk_in(k);
        bus.s_expected = mk_exp(k);
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            if (bus.s_ready) begin
                seen = 1'b1;
                break;
            end
        end
        @(posedge clock); #1;
        bus.s_valid = 1'b0;
        check("accept_seen", seen, 1);
        check("hold_in", bus.layer_in, mk_in(k));
        check("hold_exp", bus.layer_expected_out, mk_exp(k));
    endtask

    task automatic await_result(input int k, input int want_lat, input int want_s,
                                input int want_e, input int hold);
        int       lat  = 0;
        bit       seen = 1'b0;
        int       bad  = 0;
        out_vec_t want = layer_fn(mk_in(k));
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            lat++;
            if (bus.r_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("result_seen", seen, 1);
        check("latency", lat, want_lat);
        check("r_out", bus.r_out, want);
        check("sample_idx", sample_idx, want_s);
        check("epoch_idx", epoch_idx, want_e);
        if (rdy_always) begin
            @(posedge clock); #1;
        end else begin
            if (hold > 0) begin
                @(posedge clock); #1;
                bus.s_valid    = 1'b1;
                bus.s_in       = mk_in(k + 100);
                bus.s_expected = mk_exp(k + 100);
                for (int c = 0; c < hold; c++) begin
                    @(negedge clock);
                    if (!bus.r_valid || (bus.r_out !== want) || bus.s_ready ||
                        (bus.layer_in !== mk_in(k))) bad++;
                end
                check("stall_hold", bad, 0);
            end
            @(posedge clock); #1;
            bus.s_valid = 1'b0;
            bus.r_ready = 1'b1;
            @(posedge clock); #1;
            bus.r_ready = 1'b0;
        end
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        @(posedge clock); #1;
        check("done_seen", seen, 1);
    endtask

    // main sequence
    initial begin
        int b_done, b_learn, b_busy, b_srdy, b_lval;
        bit seen;

        reset_n        = 1'b0;
        start          = 1'b0;
        abort          = 1'b0;
        mode_learn     = 1'b0;
        num_samples    = '0;
        num_epochs     = '0;
        bus.s_valid    = 1'b0;
        bus.s_in       = '0;
        bus.s_expected = '0;
        bus.r_ready    = 1'b0;
        rdy_always     = 1'b0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_state", dbg_state, IDLE);
        check("rst_busy", busy, 0);
        check("rst_strobes", {bus.s_ready, bus.layer_valid, bus.layer_learn, bus.r_valid, done}, 0);
        check("rst_r_out", bus.r_out, 0);
        check("rst_idx", {sample_idx, epoch_idx}, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // infer: 3 samples, 1 epoch, r_ready held high
        rdy_always  = 1'b1;
        bus.r_ready = 1'b1;
        b_done  = done_cnt;
        b_learn = learn_cnt;
        start_run(1'b0, 3, 1);
        for (int k = 0; k < 3; k++) begin
            send_sample(k);
            await_result(k, SETTLE + 1, k, 0, 0);
        end
        wait_done();
        check("infer_done_pulses", done_cnt - b_done, 1);
        check("infer_no_learn", learn_cnt - b_learn, 0);
        check("infer_busy_after", busy, 0);
        check("infer_idx_hold", sample_idx, 2);

        // train: 2 samples, 2 epochs, 3 learn cycles each
        b_done  = done_cnt;
        b_learn = learn_cnt;
        start_run(1'b1, 2, 2);
        for (int e = 0; e < 2; e++) begin
            for (int s = 0; s < 2; s++) begin
                send_sample(10 + e * 2 + s);
                await_result(10 + e * 2 + s, SETTLE + LEARN + 1, s, e, 0);
            end
        end
        wait_done();
        check("train_learn_cycles", learn_cnt - b_learn, 12);
        check("train_done_pulses", done_cnt - b_done, 1);
        check("train_epoch_hold", epoch_idx, 1);

        // result back-pressure: r_ready low for 10 cycles in EMIT
        rdy_always  = 1'b0;
        bus.r_ready = 1'b0;
        start_run(1'b0, 2, 1);
        send_sample(50);
        await_result(50, SETTLE + 1, 0, 0, 10);
        send_sample(51);
        await_result(51, SETTLE + 1, 1, 0, 0);
        wait_done();

        // abort during LEARN, then a clean run
        rdy_always  = 1'b1;
        bus.r_ready = 1'b1;
        b_done = done_cnt;
        start_run(1'b1, 2, 1);
        send_sample(60);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (dbg_state == LEARN) begin
                seen = 1'b1;
                break;
            end
        end
        check("abort_reached_learn", seen, 1);
        @(posedge clock); #1;
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        @(negedge clock);
        check("abort_state", dbg_state, IDLE);
        check("abort_strobes", {bus.layer_learn, bus.layer_valid, bus.s_ready, bus.r_valid}, 0);
        check("abort_busy", busy, 0);
        check("abort_idx_hold", {sample_idx, epoch_idx}, 0);
        repeat (4) @(posedge clock);
        #1;
        check("abort_no_done", done_cnt - b_done, 0);
        b_done = done_cnt;
        start_run(1'b0, 1, 1);
        send_sample(61);
        await_result(61, SETTLE + 1, 0, 0, 0);
        wait_done();
        check("after_abort_done", done_cnt - b_done, 1);

        // zero sample count
        b_done = done_cnt;
        b_busy = busy_cnt;
        b_srdy = srdy_cnt;
        b_lval = lvalid_cnt;
        start_run(1'b0, 0, 4);
        repeat (5) @(posedge clock);
        #1;
        check("zero_busy_cycles", busy_cnt - b_busy, 1);
        check("zero_done_pulses", done_cnt - b_done, 1);
        check("zero_no_s_ready", srdy_cnt - b_srdy, 0);
        check("zero_no_layer_valid", lvalid_cnt - b_lval, 0);

        // asynchronous reset in the middle of SETTLE
        start_run(1'b0, 1, 1);
        send_sample(70);
        @(negedge clock);
        check("rst_mid_in_settle", dbg_state, SETTLE);
        check("rst_mid_valid_before", bus.layer_valid, 1);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_mid_state", dbg_state, IDLE);
        check("rst_mid_strobes", {bus.layer_valid, bus.layer_learn, bus.s_ready, bus.r_valid, busy, done}, 0);
        check("rst_mid_layer_in", bus.layer_in, 0);
        check("rst_mid_layer_exp", bus.layer_expected_out, 0);
        check("rst_mid_r_out", bus.r_out, 0);
        check("rst_mid_idx", {sample_idx, epoch_idx}, 0);
        #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        check("layer_valid_exclusive", excl_bad, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
